// File: rtl/mac_table_controller_if.sv
// rtl/mac_table_controller_if.sv - request, response and table RAM signals of the MAC table controller
interface mac_table_controller_if #(
    parameter int NUMBER_OF_PORTS = 2,
    parameter int ADDRESS_WIDTH   = $clog2(NUMBER_OF_PORTS) + 1
);
    logic                       learn_request_valid;
    logic                       learn_request_ready;
    logic [47:0]                learn_mac;
    logic [ADDRESS_WIDTH-1:0]   learn_port;
    logic                       lookup_request_valid;
    logic                       lookup_request_ready;
    logic [47:0]                lookup_mac;
    logic [ADDRESS_WIDTH-1:0]   lookup_source_port;
    logic                       lookup_response_valid;
    logic                       lookup_response_ready;
    logic [NUMBER_OF_PORTS-1:0] lookup_port_mask;
    logic                       lookup_hit;
    logic                       table_flush;
    logic [ADDRESS_WIDTH-1:0]   table_read_address;
    logic [47:0]                table_read_data;
    logic                       table_write_enable;
    logic [ADDRESS_WIDTH-1:0]   table_write_address;
    logic [47:0]                table_write_data;

    // Orchestrator and table RAM side
    modport master (
        output learn_request_valid, learn_mac, learn_port,
        output lookup_request_valid, lookup_mac, lookup_source_port,
        output lookup_response_ready, table_flush, table_read_data,
        input  learn_request_ready, lookup_request_ready,
        input  lookup_response_valid, lookup_port_mask, lookup_hit,
        input  table_read_address, table_write_enable, table_write_address, table_write_data
    );

    // Controller side
    modport slave (
        input  learn_request_valid, learn_mac, learn_port,
        input  lookup_request_valid, lookup_mac, lookup_source_port,
        input  lookup_response_ready, table_flush, table_read_data,
        output learn_request_ready, lookup_request_ready,
        output lookup_response_valid, lookup_port_mask, lookup_hit,
        output table_read_address, table_write_enable, table_write_address, table_write_data
    );
endinterface

// File: rtl/mac_table_controller.sv
// rtl/mac_table_controller.sv - learns source MACs and resolves destination MACs to egress port masks
module mac_table_controller #(
    parameter int NUMBER_OF_PORTS    = 2,
    parameter int TABLE_READ_LATENCY = 2,
    parameter int ADDRESS_WIDTH      = $clog2(NUMBER_OF_PORTS) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mac_table_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEARN, SCAN, DRAIN, RESPOND} state_t;

    localparam logic [ADDRESS_WIDTH-1:0]   LAST_ADDRESS = ADDRESS_WIDTH'(NUMBER_OF_PORTS - 1);
    localparam logic [ADDRESS_WIDTH-1:0]   PORT_LIMIT   = ADDRESS_WIDTH'(NUMBER_OF_PORTS);
    localparam logic [NUMBER_OF_PORTS-1:0] ALL_PORTS    = '1;

    // One-hot port bit; ports beyond the table shift out and give zero
    function automatic logic [NUMBER_OF_PORTS-1:0] port_bit(input logic [ADDRESS_WIDTH-1:0] port);
        return NUMBER_OF_PORTS'(1) << port;
    endfunction

    state_t                     state;
    logic [NUMBER_OF_PORTS-1:0] valid_bits;
    logic [47:0]                lookup_mac_reg;
    logic [ADDRESS_WIDTH-1:0]   source_port_reg;
    logic                       found;
    logic [ADDRESS_WIDTH-1:0]   found_address;
    logic                       response_valid;
    logic [NUMBER_OF_PORTS-1:0] port_mask;
    logic                       hit;
    logic [ADDRESS_WIDTH-1:0]   read_address;
    logic                       write_enable;
    logic [ADDRESS_WIDTH-1:0]   write_address;
    logic [47:0]                write_data;

    // Address tags travelling alongside the RAM read pipeline
    logic [TABLE_READ_LATENCY-1:0] pipe_valid;
    logic [TABLE_READ_LATENCY-1:0] pipe_last;
    logic [ADDRESS_WIDTH-1:0]      pipe_address [TABLE_READ_LATENCY];

    logic                       tag_valid;
    logic                       tag_last;
    logic [ADDRESS_WIDTH-1:0]   tag_address;
    logic                       match_now;
    logic                       final_hit;
    logic [ADDRESS_WIDTH-1:0]   final_address;

    assign tag_valid   = pipe_valid[TABLE_READ_LATENCY-1];
    assign tag_last    = pipe_last[TABLE_READ_LATENCY-1];
    assign tag_address = pipe_address[TABLE_READ_LATENCY-1];

    // Valid bits are sampled at compare time so a flush mid-scan affects later entries only
    assign match_now     = tag_valid && (bus.table_read_data == lookup_mac_reg)
                           && |(valid_bits & port_bit(tag_address));
    assign final_hit     = found || match_now;
    assign final_address = found ? found_address : tag_address;

    assign bus.learn_request_ready   = (state == IDLE);
    assign bus.lookup_request_ready  = (state == IDLE) && !bus.learn_request_valid;
    assign bus.lookup_response_valid = response_valid;
    assign bus.lookup_port_mask      = port_mask;
    assign bus.lookup_hit            = hit;
    assign bus.table_read_address    = read_address;
    assign bus.table_write_enable    = write_enable;
    assign bus.table_write_address   = write_address;
    assign bus.table_write_data      = write_data;

    // Delay the issued read address by the RAM latency so it lines up with its data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < TABLE_READ_LATENCY; i++) pipe_address[i] <= '0;
        end else begin
            pipe_valid[0]   <= (state == SCAN);
            pipe_last[0]    <= (state == SCAN) && (read_address == LAST_ADDRESS);
            pipe_address[0] <= read_address;
            for (int i = 1; i < TABLE_READ_LATENCY; i++) begin
                pipe_valid[i]   <= pipe_valid[i-1];
                pipe_last[i]    <= pipe_last[i-1];
                pipe_address[i] <= pipe_address[i-1];
            end
        end
    end

    // Entry valid bits: flush clears everything, a real learn write marks its entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_bits <= '0;
        end else if (bus.table_flush) begin
            valid_bits <= '0;
        end else if (state == LEARN && write_enable) begin
            valid_bits <= valid_bits | port_bit(write_address);
        end
    end

    // Request sequencing with registered table and response outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            lookup_mac_reg  <= '0;
            source_port_reg <= '0;
            found           <= 1'b0;
            found_address   <= '0;
            response_valid  <= 1'b0;
            port_mask       <= '0;
            hit             <= 1'b0;
            read_address    <= '0;
            write_enable    <= 1'b0;
            write_address   <= '0;
            write_data      <= '0;
        end else begin
            // Entries return in ascending order, so the first match is the lowest index
            if (match_now && !found) begin
                found         <= 1'b1;
                found_address <= tag_address;
            end
            case (state)
                IDLE: begin
                    if (bus.learn_request_valid) begin
                        write_address <= bus.learn_port;
                        write_data    <= bus.learn_mac;
                        write_enable  <= !bus.learn_mac[40] && (bus.learn_port < PORT_LIMIT);
                        state         <= LEARN;
                    end else if (bus.lookup_request_valid) begin
                        lookup_mac_reg  <= bus.lookup_mac;
                        source_port_reg <= bus.lookup_source_port;
                        found           <= 1'b0;
                        if (bus.lookup_mac[40]) begin
                            port_mask      <= ALL_PORTS & ~port_bit(bus.lookup_source_port);
                            hit            <= 1'b0;
                            response_valid <= 1'b1;
                            state          <= RESPOND;
                        end else begin
                            read_address <= '0;
                            state        <= SCAN;
                        end
                    end
                end
                LEARN: begin
                    write_enable <= 1'b0;
                    state        <= IDLE;
                end
                SCAN: begin
                    if (read_address == LAST_ADDRESS) begin
                        state <= DRAIN;
                    end else begin
                        read_address <= read_address + ADDRESS_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (tag_valid && tag_last) begin
                        if (!final_hit) begin
                            port_mask <= ALL_PORTS & ~port_bit(source_port_reg);
                            hit       <= 1'b0;
                        end else if (final_address == source_port_reg) begin
                            port_mask <= '0;
                            hit       <= 1'b1;
                        end else begin
                            port_mask <= port_bit(final_address);
                            hit       <= 1'b1;
                        end
                        response_valid <= 1'b1;
                        state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (bus.lookup_response_ready) begin
                        response_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
